io_uart_tx: RTL and testbench
=============================

IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 Parameter p_data_width, default 16: IO data bus width.
REQ-002 Parameter p_port_width, default 8: IO port address width.
REQ-003 Parameter p_base_port, default 8'h10: base port; DATA = base+0, STATUS = base+1, DIV = base+2.
REQ-004 Parameter p_reset_divisor, default 16'd15: DIV reset value.
REQ-005 i_w_clk  in  1: single clock, all state updates on its rising edge.
REQ-006 i_w_reset  in  1: asynchronous active-low reset (0 = reset).
REQ-007 i_w_io_oe  in  1: CPU IO read strobe.
REQ-008 i_w_io_we  in  1: CPU IO write strobe.
REQ-009 i_w_io_port  in  p_port_width: CPU IO port address.
REQ-010 i_w_io_in  in  p_data_width: CPU write data.
REQ-011 o_w_io_out  out  p_data_width: read data to CPU, combinational.
REQ-012 o_w_tx  out  1: serial line, idle high.

Function
REQ-013 o_w_io_out SHALL be 0 unless i_w_io_oe=1 and the port is STATUS or DIV; a DATA read returns 0 (OR-combinable with other peripherals).
REQ-014 STATUS read value: bit0 empty, bit1 full, bit2 busy (FSM not IDLE), bit3 overflow, bits[6:4] FIFO count (0..4), all other bits 0.
REQ-015 DIV read returns the 16-bit divisor register; each serial bit lasts DIV+1 clock cycles (DIV=0 gives 1 cycle).
REQ-016 Write to DIV (we=1, port=DIV) SHALL update the register at the edge; a running frame uses the new value from the next bit boundary onward.
REQ-017 Write to DATA SHALL push i_w_io_in[7:0] into a 4-entry FIFO; bits above 7 are ignored.
REQ-018 Write to DATA when FIFO full (count before the edge = 4) SHALL be dropped and set overflow, even if a pop occurs on the same edge.
REQ-019 Overflow SHALL be sticky and clear on the rising edge at which oe=1 and port=STATUS; a set and a clear on the same edge leaves it set.
REQ-020 Accesses to any other port, or with both strobes low, SHALL change no state.
REQ-021 oe and we asserted together SHALL both take effect; the read returns the pre-edge value.
REQ-022 FSM states: IDLE, START, DATA, STOP.
REQ-023 IDLE with FIFO non-empty: pop at the edge, go to START.
REQ-024 START: o_w_tx=0 for one bit period, then go to DATA.
REQ-025 DATA: 8 bits, LSB first, one bit period each, then go to STOP.
REQ-026 STOP: o_w_tx=1 for one bit period; at its end, pop directly to START if the FIFO is non-empty, else go to IDLE.
REQ-027 o_w_tx SHALL be registered and high in IDLE and STOP.
REQ-028 Latency: with FSM IDLE and FIFO empty, a DATA write at edge k makes o_w_tx low after edge k+1.
REQ-029 Pops occur only per REQ-023 and REQ-026; a simultaneous push and pop keeps order and leaves the count unchanged.
REQ-030 FIFO pointers SHALL wrap modulo 4.

Reset
REQ-031 While i_w_reset=0, independent of clock: o_w_tx=1, FSM IDLE, FIFO empty with pointers 0, overflow=0, DIV=p_reset_divisor, bit and cycle counters 0.
REQ-032 Reset mid-frame SHALL abort the frame; no residual bits are sent after release.
REQ-033 First state change after reset SHALL occur at the first rising edge with i_w_reset=1.

Verification
REQ-034 After reset: o_w_tx=1, STATUS read = 16'h0001, DIV read = 16'h000F.
REQ-035 Write DIV=3, then DATA=16'h0155: o_w_tx is low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles (40-cycle frame); the upper byte is ignored.
REQ-036 With IDLE and DIV=3, write DATA six times on consecutive edges: five frames are sent back-to-back with no idle gap, the sixth write is dropped, and STATUS bit3=1.
REQ-037 After REQ-036, read STATUS twice: the first read has bit3=1, the second has bit3=0.
REQ-038 Assert reset during data bit 3: o_w_tx=1 immediately; after release STATUS reads 16'h0001 and o_w_tx stays high.
REQ-039 Read and write port base+3 with data 16'hFFFF: o_w_io_out=0 and STATUS and DIV are unchanged.

Source files
------------

// File: rtl/io_uart_tx_if.sv
// CPU IO-port bus as seen by the UART transmitter.
// The master drives strobes, address and write data; the slave returns read data.
`timescale 1ns/1ps
interface io_uart_tx_if #(
    parameter int unsigned p_data_width = 16,
    parameter int unsigned p_port_width = 8
);
    logic                    i_w_io_oe;
    logic                    i_w_io_we;
    logic [p_port_width-1:0] i_w_io_port;
    logic [p_data_width-1:0] i_w_io_in;
    logic [p_data_width-1:0] o_w_io_out;

    modport master (
        output i_w_io_oe,
        output i_w_io_we,
        output i_w_io_port,
        output i_w_io_in,
        input  o_w_io_out
    );

    modport slave (
        input  i_w_io_oe,
        input  i_w_io_we,
        input  i_w_io_port,
        input  i_w_io_in,
        output o_w_io_out
    );
endinterface

// File: rtl/io_uart_tx.sv
// IO-mapped UART transmitter: 4-entry byte FIFO, programmable bit divisor,
// 8N1 framing with back-to-back frames when the FIFO has more data.
`timescale 1ns/1ps
module io_uart_tx #(
    parameter int unsigned             p_data_width    = 16,
    parameter int unsigned             p_port_width    = 8,
    parameter logic [p_port_width-1:0] p_base_port     = 8'h10,
    parameter logic [15:0]             p_reset_divisor = 16'd15
) (
    input  logic        i_w_clk,
    input  logic        i_w_reset,
    io_uart_tx_if.slave io,
    output logic        o_w_tx
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [p_port_width-1:0] lp_port_data   = p_base_port;
    localparam logic [p_port_width-1:0] lp_port_status = p_base_port + p_port_width'(1);
    localparam logic [p_port_width-1:0] lp_port_div    = p_base_port + p_port_width'(2);

    logic [1:0]  state_q, state_d;
    logic        tx_q, tx_d;
    logic [15:0] cyc_q, cyc_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] cur_div_q, cur_div_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  fifo_q [4];
    logic [7:0]  fifo_d [4];

    logic sel_data, sel_status, sel_div;
    logic empty, full, busy;
    logic wr_data, push, pop, ovf_set, status_rd, bit_end;
    logic [15:0] status;

    assign sel_data   = (io.i_w_io_port == lp_port_data);
    assign sel_status = (io.i_w_io_port == lp_port_status);
    assign sel_div    = (io.i_w_io_port == lp_port_div);

    assign empty     = (count_q == 3'd0);
    assign full      = (count_q == 3'd4);
    assign busy      = (state_q != S_IDLE);
    assign wr_data   = io.i_w_io_we && sel_data;
    assign push      = wr_data && !full;
    assign ovf_set   = wr_data && full;
    assign status_rd = io.i_w_io_oe && sel_status;
    assign bit_end   = (cyc_q == cur_div_q);

    assign status = {9'd0, count_q, ovf_q, busy, full, empty};

    // Read data is zero unless selected so it can be OR-ed with other peripherals.
    always_comb begin
        io.o_w_io_out = '0;
        if (io.i_w_io_oe && sel_status) begin
            io.o_w_io_out = p_data_width'(status);
        end else if (io.i_w_io_oe && sel_div) begin
            io.o_w_io_out = p_data_width'(div_q);
        end
    end

    always_comb begin
        div_d = div_q;
        if (io.i_w_io_we && sel_div) begin
            div_d = io.i_w_io_in[15:0];
        end
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (status_rd) begin
            ovf_d = 1'b0;
        end
    end

    // Each bit boundary latches the divisor, so a DIV write never stretches the current bit.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        cyc_d     = cyc_q;
        bit_d     = bit_q;
        cur_div_d = cur_div_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                    cyc_d     = '0;
                    bit_d     = '0;
                    cur_div_d = div_d;
                    shreg_d   = fifo_q[rd_ptr_q];
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    tx_d      = shreg_q[0];
                    cyc_d     = '0;
                    bit_d     = '0;
                    cur_div_d = div_d;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_d     = '0;
                    cur_div_d = div_d;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: begin
                if (bit_end) begin
                    cyc_d     = '0;
                    cur_div_d = div_d;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                        bit_d   = '0;
                        shreg_d = fifo_q[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = io.i_w_io_in[7:0];
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            cyc_q     <= '0;
            bit_q     <= '0;
            cur_div_q <= p_reset_divisor;
            div_q     <= p_reset_divisor;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
            cur_div_q <= cur_div_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage only; validity is tracked by the reset-cleared pointers and count.
    always_ff @(posedge i_w_clk) begin
        fifo_q  <= fifo_d;
        shreg_q <= shreg_d;
    end

    assign o_w_tx = tx_q;
endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: directed register/FIFO accesses plus a line monitor
// that decodes every frame against a queue of expected bytes.
`timescale 1ns/1ps
module tb_io_uart_tx;
    localparam logic [7:0] P_DATA   = 8'h10;
    localparam logic [7:0] P_STATUS = 8'h11;
    localparam logic [7:0] P_DIV    = 8'h12;
    localparam logic [7:0] P_OTHER  = 8'h13;

    logic clk;
    logic rst_n;
    logic tx;

    io_uart_tx_if #(.p_data_width(16), .p_port_width(8)) bus_if ();

    io_uart_tx dut (
        .i_w_clk   (clk),
        .i_w_reset (rst_n),
        .io        (bus_if),
        .o_w_tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int         gaps[$];
    int         frames_done = 0;
    int         mon_div = 15;
    int         idle_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One bus cycle: drive at a falling edge, sample read data, cross one rising edge.
    task automatic bus(input logic oe, input logic we, input logic [7:0] port,
                       input logic [15:0] data, output logic [15:0] rd);
        bus_if.i_w_io_oe   = oe;
        bus_if.i_w_io_we   = we;
        bus_if.i_w_io_port = port;
        bus_if.i_w_io_in   = data;
        #1 rd = bus_if.o_w_io_out;
        @(negedge clk);
    endtask

    task automatic idle();
        bus_if.i_w_io_oe   = 1'b0;
        bus_if.i_w_io_we   = 1'b0;
        bus_if.i_w_io_port = 8'h00;
        bus_if.i_w_io_in   = 16'h0000;
        @(negedge clk);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            idle();
            n++;
        end
        check("frames_done", frames_done, target);
    endtask

    // Line monitor
    logic [7:0] m_exp, m_got;
    int         m_bad, m_per, m_b;
    logic       m_e, m_abort;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                gaps.push_back(idle_run);
                idle_run = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", exp_q.size(), 1);
                    m_exp = 8'h00;
                end else begin
                    m_exp = exp_q.pop_front();
                end
                m_per   = mon_div + 1;
                m_bad   = 0;
                m_got   = 8'h00;
                m_abort = 1'b0;
                for (int i = 0; i < 10 * m_per; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        m_abort = 1'b1;
                        break;
                    end
                    m_b = i / m_per;
                    if (m_b == 0) m_e = 1'b0;
                    else if (m_b == 9) m_e = 1'b1;
                    else m_e = m_exp[m_b-1];
                    if (m_b >= 1 && m_b <= 8 && (i % m_per) == 0) m_got[m_b-1] = tx;
                    if (tx !== m_e) m_bad++;
                end
                if (!m_abort) begin
                    check("frame_byte", m_got, m_exp);
                    check("frame_timing_errs", m_bad, 0);
                    frames_done++;
                end
            end else if (tx === 1'b1) begin
                idle_run++;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [15:0] rd;
    logic [7:0]  burst [6];
    int          base, gsum, high_ok;

    initial begin
        burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rst_n = 1'b0;
        bus_if.i_w_io_oe   = 1'b0;
        bus_if.i_w_io_we   = 1'b0;
        bus_if.i_w_io_port = 8'h00;
        bus_if.i_w_io_in   = 16'h0000;
        repeat (3) @(negedge clk);
        check("tx_in_reset", tx, 1);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("tx_after_reset", tx, 1);
        bus(1, 0, P_STATUS, 16'h0, rd); check("status_reset", rd, 16'h0001);
        bus(1, 0, P_DIV, 16'h0, rd);    check("div_reset", rd, 16'h000F);

        // Single frame, DIV=3, upper byte ignored
        mon_div = 3;
        bus(0, 1, P_DIV, 16'd3, rd);
        bus(1, 0, P_DIV, 16'h0, rd); check("div_write", rd, 16'h0003);
        exp_q.push_back(8'h55);
        bus(0, 1, P_DATA, 16'h0155, rd); check("latency_pre", tx, 1);
        idle();                          check("latency_post", tx, 0);
        wait_frames(1, 100);
        repeat (3) idle();
        bus(1, 0, P_STATUS, 16'h0, rd); check("status_idle", rd, 16'h0001);

        // DIV=0: one cycle per bit
        mon_div = 0;
        bus(0, 1, P_DIV, 16'd0, rd);
        exp_q.push_back(8'hA3);
        bus(0, 1, P_DATA, 16'h00A3, rd);
        wait_frames(2, 40);
        repeat (3) idle();
        bus(0, 1, P_DIV, 16'd3, rd);
        mon_div = 3;
        idle();

        // Six writes on consecutive edges: five frames, sixth dropped
        gaps.delete();
        base = frames_done;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(burst[i]);
            bus(0, 1, P_DATA, {8'hA5, burst[i]}, rd);
        end
        bus(1, 0, P_STATUS, 16'h0, rd); check("status_ovf_set", rd, 16'h004E);
        bus(1, 0, P_STATUS, 16'h0, rd); check("status_ovf_clr", rd, 16'h0046);
        wait_frames(base + 5, 260);
        gsum = 999;
        if (gaps.size() == 5) gsum = gaps[1] + gaps[2] + gaps[3] + gaps[4];
        check("burst_gaps", gsum, 0);
        repeat (60) idle();
        check("no_sixth_frame", frames_done, base + 5);
        bus(1, 0, P_STATUS, 16'h0, rd); check("status_after_burst", rd, 16'h0001);

        // Unmapped port and non-readable accesses
        base = frames_done;
        bus(1, 1, P_OTHER, 16'hFFFF, rd); check("unmapped_read", rd, 16'h0000);
        bus(1, 0, P_DATA, 16'h0, rd);     check("data_read_zero", rd, 16'h0000);
        bus(0, 0, P_STATUS, 16'h0, rd);   check("no_oe_read_zero", rd, 16'h0000);
        bus(1, 0, P_STATUS, 16'h0, rd);   check("status_unchanged", rd, 16'h0001);
        bus(1, 0, P_DIV, 16'h0, rd);      check("div_unchanged", rd, 16'h0003);
        repeat (20) idle();
        check("no_frame_unmapped", frames_done, base);

        // Reset during data bit 3
        exp_q.push_back(8'hF7);
        bus(0, 1, P_DATA, 16'h00F7, rd);
        idle();
        repeat (17) idle();
        check("bit3_before_reset", tx, 0);
        #2 rst_n = 1'b0;
        #1 check("tx_async_reset", tx, 1);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        mon_div = 15;
        @(negedge clk);
        bus(1, 0, P_STATUS, 16'h0, rd); check("status_after_abort", rd, 16'h0001);
        bus(1, 0, P_DIV, 16'h0, rd);    check("div_after_abort", rd, 16'h000F);
        high_ok = 0;
        for (int i = 0; i < 60; i++) begin
            idle();
            if (tx === 1'b1) high_ok++;
        end
        check("tx_high_after_abort", high_ok, 60);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
